// File: rtl/aska_mch_npg_if.sv
// rtl/aska_mch_npg_if.sv - register write port bundle for aska_mch_npg
//
// Signals:
//   cfg_we     one-cycle register write strobe
//   cfg_addr   word address = ch*4 + word
//   cfg_wdata  32-bit write data
// Modports: master drives the write port (SPI front end / bench), slave receives it.
interface aska_mch_npg_if #(
    parameter int N_CH = 2
) ();
    localparam int ADDR_W = $clog2(N_CH) + 2;

    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [31:0]       cfg_wdata;

    modport master (output cfg_we, cfg_addr, cfg_wdata);
    modport slave  (input  cfg_we, cfg_addr, cfg_wdata);
endinterface

// File: rtl/aska_mch_npg.sv
// rtl/aska_mch_npg.sv - multi-channel biphasic neuromuscular pulse generator
//
// N_CH channels with independent period, amplitude, ramp and ON/OFF cycling
// share one H-bridge and DAC through a round-robin arbiter.
// Optional macro: ASKA_INTERPHASE_EN inserts a PW_UNIT-cycle gap between phases.
//
// Ports:
//   clk            system clock
//   reset          synchronous active-high reset
//   cfg            register write port (aska_mch_npg_if.slave)
//   up_switches    P-switch enables
//   down_switches  N-switch enables
//   DAC            current amplitude code, non-zero only during the phases
//   pulse_active   high for the whole pulse (PHASE1 through PHASE2)
//   active_ch      channel being pulsed, 0 when idle
//   overrun        sticky per-channel missed-pulse flags, cleared by a word1 write
module aska_mch_npg #(
    parameter int N_CH     = 2,
    parameter int ELEC_NUM = 8,
    parameter int DAC_W    = 6,
    parameter int PW_UNIT  = 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    aska_mch_npg_if.slave                            cfg,
    output logic [ELEC_NUM-1:0]                      up_switches,
    output logic [ELEC_NUM-1:0]                      down_switches,
    output logic [DAC_W-1:0]                         DAC,
    output logic                                     pulse_active,
    output logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] active_ch,
    output logic [N_CH-1:0]                          overrun
);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int ADDR_W = $clog2(N_CH) + 2;

    typedef enum logic [1:0] {S_IDLE, S_PHASE1, S_INTER, S_PHASE2} state_t;

    // configuration registers
    logic [11:0]         freq_r [N_CH];
    logic [DAC_W-1:0]    amp_r  [N_CH];
    logic [9:0]          rf_r   [N_CH];
    logic [2:0]          pd_r   [N_CH];
    logic [7:0]          on_r   [N_CH];
    logic [9:0]          off_r  [N_CH];
    logic [ELEC_NUM-1:0] an_r   [N_CH];
    logic [ELEC_NUM-1:0] ca_r   [N_CH];
    logic [N_CH-1:0]     en_r;

    // per-channel timing state
    logic [11:0]     cnt     [N_CH];
    logic [9:0]      per_cnt [N_CH];
    logic [13:0]     acc     [N_CH];
    logic [N_CH-1:0] off_mode;
    logic [N_CH-1:0] pending;

    logic [N_CH-1:0] wr_sel, wr_w1, en, fire, new_win, off_nx, req;
    logic [9:0]      per_nx [N_CH];

    // arbiter / shadow / FSM
    logic                gnt_vld;
    logic [CH_W-1:0]     gnt_ch;
    logic [CH_W-1:0]     rr_ptr;
    logic [13:0]         acc_base, acc_sat;
    logic [14:0]         acc_sum;
    logic [9:0]          ramp_amp;
    logic [DAC_W-1:0]    amp_used;
    logic [15:0]         gnt_len;
    state_t              state, state_nx;
    logic [15:0]         ph_cnt, ph_cnt_nx;
    logic [ELEC_NUM-1:0] sh_an, sh_ca;
    logic [DAC_W-1:0]    sh_amp;
    logic [15:0]         sh_len;
    logic [CH_W-1:0]     sh_ch;

    logic unused_wdata;
    assign unused_wdata = ^cfg.cfg_wdata;

    // Write decode, channel enable and ON/OFF window bookkeeping.
    // A period boundary is cnt==0 while enabled; the window state tells
    // whether that boundary issues a pulse request.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            wr_sel[i]  = cfg.cfg_we && ((cfg.cfg_addr >> 2) == ADDR_W'(i));
            wr_w1[i]   = wr_sel[i] && (cfg.cfg_addr[1:0] == 2'd1);
            en[i]      = en_r[i] && (freq_r[i] >= 12'd2);
            fire[i]    = 1'b0;
            new_win[i] = 1'b0;
            off_nx[i]  = off_mode[i];
            per_nx[i]  = per_cnt[i];
            if (en[i] && cnt[i] == 12'd0) begin
                if (!off_mode[i]) begin
                    if (on_r[i] == 8'd0) begin
                        fire[i] = 1'b1;
                    end else if (per_cnt[i] < {2'b00, on_r[i]}) begin
                        fire[i]   = 1'b1;
                        per_nx[i] = per_cnt[i] + 10'd1;
                    end else if (off_r[i] == 10'd0) begin
                        fire[i]    = 1'b1;
                        new_win[i] = 1'b1;
                        per_nx[i]  = 10'd1;
                    end else begin
                        off_nx[i] = 1'b1;
                        per_nx[i] = 10'd1;
                    end
                end else begin
                    if (per_cnt[i] < off_r[i]) begin
                        per_nx[i] = per_cnt[i] + 10'd1;
                    end else begin
                        off_nx[i]  = 1'b0;
                        fire[i]    = 1'b1;
                        new_win[i] = 1'b1;
                        per_nx[i]  = 10'd1;
                    end
                end
            end
            // A fresh boundary is granted in the same cycle it occurs, which
            // gives the two-cycle write-to-PHASE1 latency.
            req[i] = en[i] && (fire[i] || pending[i]);
        end
    end

    // Circular search starting at the channel after the last grant.
    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        idx     = 0;
        if (state == S_IDLE) begin
            for (int k = 0; k < N_CH; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N_CH) idx = idx - N_CH;
                if (!gnt_vld && req[CH_W'(idx)]) begin
                    gnt_vld = 1'b1;
                    gnt_ch  = CH_W'(idx);
                end
            end
        end
    end

    // Ramp step for the granted channel; a window start in the same cycle
    // restarts the ramp from zero before the step.
    always_comb begin
        acc_base = new_win[gnt_ch] ? 14'd0 : acc[gnt_ch];
        acc_sum  = {1'b0, acc_base} + {5'd0, rf_r[gnt_ch]};
        acc_sat  = acc_sum[14] ? 14'h3fff : acc_sum[13:0];
        ramp_amp = acc_sat[13:4];
        if (rf_r[gnt_ch] == 10'd0)
            amp_used = amp_r[gnt_ch];
        else if ({6'd0, ramp_amp} < 16'(amp_r[gnt_ch]))
            amp_used = DAC_W'(ramp_amp);
        else
            amp_used = amp_r[gnt_ch];
        gnt_len = 16'((pd_r[gnt_ch] == 3'd0) ? 3'd1 : pd_r[gnt_ch]) * 16'(PW_UNIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                freq_r[i]  <= '0;
                amp_r[i]   <= '0;
                rf_r[i]    <= '0;
                pd_r[i]    <= '0;
                on_r[i]    <= '0;
                off_r[i]   <= '0;
                an_r[i]    <= '0;
                ca_r[i]    <= '0;
                cnt[i]     <= '0;
                per_cnt[i] <= '0;
                acc[i]     <= '0;
            end
            en_r     <= '0;
            off_mode <= '0;
            pending  <= '0;
            overrun  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (wr_sel[i]) begin
                    case (cfg.cfg_addr[1:0])
                        2'd0: begin
                            freq_r[i] <= cfg.cfg_wdata[11:0];
                            amp_r[i]  <= cfg.cfg_wdata[12 +: DAC_W];
                            rf_r[i]   <= cfg.cfg_wdata[27:18];
                            pd_r[i]   <= cfg.cfg_wdata[30:28];
                        end
                        2'd1: begin
                            on_r[i]  <= cfg.cfg_wdata[7:0];
                            off_r[i] <= cfg.cfg_wdata[17:8];
                            en_r[i]  <= cfg.cfg_wdata[18];
                        end
                        2'd2:    an_r[i] <= cfg.cfg_wdata[ELEC_NUM-1:0];
                        default: ca_r[i] <= cfg.cfg_wdata[ELEC_NUM-1:0];
                    endcase
                end
                // Disabled channels hold all counters cleared so that the
                // next enable starts a fresh ON window with an empty ramp.
                if (!en[i]) begin
                    cnt[i]      <= '0;
                    per_cnt[i]  <= '0;
                    acc[i]      <= '0;
                    off_mode[i] <= 1'b0;
                    pending[i]  <= 1'b0;
                end else begin
                    cnt[i]      <= (cnt[i] >= freq_r[i] - 12'd1) ? 12'd0 : cnt[i] + 12'd1;
                    per_cnt[i]  <= per_nx[i];
                    off_mode[i] <= off_nx[i];
                    if (gnt_vld && gnt_ch == CH_W'(i)) begin
                        acc[i]     <= acc_sat;
                        pending[i] <= 1'b0;
                    end else begin
                        if (new_win[i]) acc[i] <= '0;
                        pending[i] <= pending[i] | fire[i];
                    end
                end
                overrun[i] <= wr_w1[i] ? 1'b0 : (overrun[i] | (fire[i] & pending[i]));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            ph_cnt <= '0;
            rr_ptr <= '0;
            sh_an  <= '0;
            sh_ca  <= '0;
            sh_amp <= '0;
            sh_len <= '0;
            sh_ch  <= '0;
        end else begin
            state  <= state_nx;
            ph_cnt <= ph_cnt_nx;
            if (gnt_vld) begin
                rr_ptr <= (int'(gnt_ch) == N_CH - 1) ? '0 : gnt_ch + CH_W'(1);
                sh_an  <= an_r[gnt_ch];
                sh_ca  <= ca_r[gnt_ch];
                sh_amp <= amp_used;
                sh_len <= gnt_len;
                sh_ch  <= gnt_ch;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        ph_cnt_nx     = ph_cnt + 16'd1;
        up_switches   = '0;
        down_switches = '0;
        DAC           = '0;
        pulse_active  = (state != S_IDLE);
        active_ch     = (state != S_IDLE) ? sh_ch : '0;
        case (state)
            S_IDLE: begin
                ph_cnt_nx = '0;
                if (gnt_vld) state_nx = S_PHASE1;
            end
            S_PHASE1: begin
                up_switches   = sh_an & ~sh_ca;
                down_switches = sh_ca & ~sh_an;
                DAC           = sh_amp;
                if (ph_cnt == sh_len - 16'd1) begin
                    ph_cnt_nx = '0;
`ifdef ASKA_INTERPHASE_EN
                    state_nx  = S_INTER;
`else
                    state_nx  = S_PHASE2;
`endif
                end
            end
            S_INTER: begin
                if (ph_cnt == 16'(PW_UNIT - 1)) begin
                    ph_cnt_nx = '0;
                    state_nx  = S_PHASE2;
                end
            end
            default: begin
                up_switches   = sh_ca & ~sh_an;
                down_switches = sh_an & ~sh_ca;
                DAC           = sh_amp;
                if (ph_cnt == sh_len - 16'd1) begin
                    ph_cnt_nx = '0;
                    state_nx  = S_IDLE;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_aska_mch_npg.sv
// tb/tb_aska_mch_npg.sv - directed self-checking bench for aska_mch_npg
module tb_aska_mch_npg;
`ifdef ASKA_INTERPHASE_EN
    localparam int IP = 1;
`else
    localparam int IP = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] up_switches, down_switches;
    logic [5:0] DAC;
    logic       pulse_active;
    logic [0:0] active_ch;
    logic [1:0] overrun;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    aska_mch_npg_if #(.N_CH(2)) cfg_if ();

    aska_mch_npg #(.N_CH(2), .ELEC_NUM(8), .DAC_W(6), .PW_UNIT(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg           (cfg_if),
        .up_switches   (up_switches),
        .down_switches (down_switches),
        .DAC           (DAC),
        .pulse_active  (pulse_active),
        .active_ch     (active_ch),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int word, input logic [31:0] data);
        @(negedge clk);
        cfg_if.cfg_we    = 1'b1;
        cfg_if.cfg_addr  = 3'(ch * 4 + word);
        cfg_if.cfg_wdata = data;
        @(posedge clk);
        #1;
        cfg_if.cfg_we = 1'b0;
    endtask

    function automatic logic [31:0] w0(input int freq, input int amp, input int rf, input int pd);
        return 32'(freq) | (32'(amp) << 12) | (32'(rf) << 18) | (32'(pd) << 28);
    endfunction

    // Walk one pulse starting at its first PHASE1 cycle; ends on the idle cycle after it.
    task automatic pulse(input string tag, input int ch, input int up1, input int dn1,
                         input int amp, input int len);
        for (int c = 0; c < len; c++) begin
            check({tag, "_p1_up"}, up_switches, up1);
            check({tag, "_p1_dn"}, down_switches, dn1);
            check({tag, "_p1_dac"}, DAC, amp);
            check({tag, "_p1_pa"}, pulse_active, 1);
            check({tag, "_p1_ch"}, active_ch, ch);
            step();
        end
        if (IP == 1) begin
            check({tag, "_ip_pa"}, pulse_active, 1);
            check({tag, "_ip_up"}, up_switches, 0);
            check({tag, "_ip_dac"}, DAC, 0);
            step();
        end
        for (int c = 0; c < len; c++) begin
            check({tag, "_p2_up"}, up_switches, dn1);
            check({tag, "_p2_dn"}, down_switches, up1);
            check({tag, "_p2_dac"}, DAC, amp);
            step();
        end
        check({tag, "_end_pa"}, pulse_active, 0);
    endtask

    task automatic next_pulse(input string tag, input int limit);
        int n = 0;
        while (pulse_active && n < limit) begin step(); n++; end
        while (!pulse_active && n < limit) begin step(); n++; end
        check({tag, "_seen"}, pulse_active, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_up"}, up_switches, 0);
        check({tag, "_dn"}, down_switches, 0);
        check({tag, "_dac"}, DAC, 0);
        check({tag, "_pa"}, pulse_active, 0);
        check({tag, "_ach"}, active_ch, 0);
        check({tag, "_ovr"}, overrun, 0);
    endtask

    initial begin
        int t0;
        int gaps [6];
        int amps [6];
        int pa_cycles;

        cfg_if.cfg_we = 1'b0;
        cfg_if.cfg_addr = '0;
        cfg_if.cfg_wdata = '0;
        repeat (3) step();
        check_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // basic biphasic pulse and period
        wr(0, 0, w0(400, 20, 0, 2));
        wr(0, 2, 32'h01);
        wr(0, 3, 32'h02);
        wr(0, 1, 32'h1 << 18);
        check("lat_before", pulse_active, 0);
        step();
        t0 = cyc;
        pulse("t1a", 0, 1, 2, 20, 2);
        next_pulse("t1b", 500);
        check("t1_period", cyc - t0, 400);
        pulse("t1b", 0, 1, 2, 20, 2);
        wr(0, 1, 0);

        // ramp, continuous ON
        wr(0, 0, w0(100, 40, 64, 1));
        wr(0, 1, 32'h1 << 18);
        for (int n = 1; n <= 12; n++) begin
            next_pulse("ramp", 150);
            check($sformatf("ramp_dac%0d", n), DAC, (4 * n < 40) ? 4 * n : 40);
        end
        wr(0, 1, 0);
        repeat (5) step();

        // ON/OFF cycling with ramp restart
        gaps = '{0, 100, 100, 300, 100, 100};
        amps = '{4, 8, 12, 4, 8, 12};
        wr(0, 1, (32'h1 << 18) | (32'd2 << 8) | 32'd3);
        for (int n = 0; n < 6; n++) begin
            next_pulse("onoff", 400);
            if (n == 0) t0 = cyc;
            check($sformatf("onoff_gap%0d", n), cyc - t0, gaps[n]);
            check($sformatf("onoff_dac%0d", n), DAC, amps[n]);
            t0 = cyc;
        end
        wr(0, 1, 0);
        repeat (5) step();

        // two-channel round robin
        wr(0, 0, w0(50, 10, 0, 7));
        wr(1, 0, w0(50, 30, 0, 7));
        wr(1, 2, 32'h04);
        wr(1, 3, 32'h08);
        wr(0, 1, 32'h1 << 18);
        wr(1, 1, 32'h1 << 18);
        t0 = cyc;
        check("rr_a_ch", active_ch, 0);
        check("rr_a_dac", DAC, 10);
        next_pulse("rr_b", 40);
        check("rr_b_gap", cyc - t0, 15 + IP);
        check("rr_b_ch", active_ch, 1);
        check("rr_b_up", up_switches, 8'h04);
        check("rr_b_dac", DAC, 30);
        next_pulse("rr_c", 60);
        check("rr_c_gap", cyc - t0, 50);
        check("rr_c_ch", active_ch, 0);
        next_pulse("rr_d", 40);
        check("rr_d_ch", active_ch, 1);

        // overrun on ch1, sticky until word1 write
        wr(1, 0, w0(10, 30, 0, 7));
        repeat (200) step();
        check("ovr1_set", overrun[1], 1);
        check("ovr0_clear", overrun[0], 0);
        repeat (50) step();
        check("ovr1_sticky", overrun[1], 1);
        wr(1, 1, 0);
        check("ovr1_cleared", overrun[1], 0);

        // enable cleared mid-PHASE1
        wr(0, 1, 0);
        begin
            int n = 0;
            while (pulse_active && n < 40) begin step(); n++; end
        end
        check("dis_idle", pulse_active, 0);
        wr(0, 0, w0(400, 20, 0, 2));
        wr(0, 1, 32'h1 << 18);
        step();
        check("dis_p1a_up", up_switches, 1);
        wr(0, 1, 0);
        check("dis_p1b_up", up_switches, 1);
        check("dis_p1b_dac", DAC, 20);
        step();
        if (IP == 1) begin
            check("dis_ip_pa", pulse_active, 1);
            step();
        end
        check("dis_p2a_up", up_switches, 2);
        check("dis_p2a_dn", down_switches, 1);
        step();
        check("dis_p2b_up", up_switches, 2);
        step();
        check("dis_end", pulse_active, 0);
        pa_cycles = 0;
        for (int c = 0; c < 500; c++) begin
            step();
            if (pulse_active) pa_cycles++;
        end
        check("dis_no_more", pa_cycles, 0);

        // reset mid-PHASE2
        wr(0, 0, w0(400, 20, 0, 7));
        wr(0, 1, 32'h1 << 18);
        step();
        repeat (7 + IP) step();
        check("rst_in_p2", up_switches, 2);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("rst_mid");
        step();
        @(negedge clk);
        reset = 1'b0;

        // overlapping masks never drive switches
        wr(0, 0, w0(400, 20, 0, 2));
        wr(0, 2, 32'h0F);
        wr(0, 3, 32'h0F);
        wr(0, 1, 32'h1 << 18);
        step();
        pulse("ovl", 0, 0, 0, 20, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
